// File: rtl/wb_commit.sv
// Writeback commit: selects W-stage write data, commits it to the 32x32 GRF
// (with same-cycle read bypass) and records each architectural write in a trace FIFO.
module wb_commit #(
    parameter int TRACE_DEPTH = 8,
    parameter int DROP_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       W_AO,
    input  logic [31:0]       W_DR,
    input  logic [31:0]       W_pc,
    input  logic [31:0]       W_pc8,
    input  logic [4:0]        W_A3,
    input  logic [1:0]        SelWout_W,
    input  logic              RegWrite_W,
    input  logic [4:0]        D_A1,
    input  logic [4:0]        D_A2,
    output logic [31:0]       D_RD1,
    output logic [31:0]       D_RD2,
    output logic [31:0]       W_WD,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_pc,
    output logic [4:0]        trace_a3,
    output logic [31:0]       trace_wd,
    output logic              trace_full,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam logic [PW:0]       PTR_ONE  = 1;
    localparam logic [DROP_W-1:0] DROP_ONE = 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  a3;
        logic [31:0] wd;
    } trace_t;

    logic [31:0]       grf_q [32];
    logic [31:0]       grf_d [32];
    trace_t            mem_q [TRACE_DEPTH];
    trace_t            mem_d [TRACE_DEPTH];
    logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              commit, empty, full, pop, push;
    trace_t            head;

    always_comb begin
        case (SelWout_W)
            2'd0:    W_WD = W_AO;
            2'd1:    W_WD = W_DR;
            2'd2:    W_WD = W_pc8;
            default: W_WD = 32'd0;
        endcase
    end

    assign commit = RegWrite_W && (W_A3 != 5'd0);

    always_comb begin
        if (D_A1 == 5'd0)                    D_RD1 = 32'd0;
        else if (commit && (D_A1 == W_A3))   D_RD1 = W_WD;
        else                                 D_RD1 = grf_q[D_A1];
    end

    always_comb begin
        if (D_A2 == 5'd0)                    D_RD2 = 32'd0;
        else if (commit && (D_A2 == W_A3))   D_RD2 = W_WD;
        else                                 D_RD2 = grf_q[D_A2];
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign pop   = !empty && trace_ready;
    // A pop in the same cycle frees the slot the push lands in, so full+pop still accepts.
    assign push  = commit && (!full || pop);

    always_comb begin
        grf_d      = grf_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (commit) begin
            grf_d[W_A3] = W_WD;
            if (push) begin
                mem_d[wr_ptr_q[PW-1:0]] = '{pc: W_pc, a3: W_A3, wd: W_WD};
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) grf_q[i] <= 32'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            grf_q      <= grf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Payload storage needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head        = mem_q[rd_ptr_q[PW-1:0]];
    assign trace_valid = !empty;
    assign trace_full  = full;
    assign trace_pc    = head.pc;
    assign trace_a3    = head.a3;
    assign trace_wd    = head.wd;
    assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed plan steps followed by random traffic, all
// checked against a queue-based reference model of the GRF and trace FIFO.
module tb_wb_commit;
    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   W_AO, W_DR, W_pc, W_pc8;
    logic [4:0]    W_A3;
    logic [1:0]    SelWout_W;
    logic          RegWrite_W;
    logic [4:0]    D_A1, D_A2;
    logic [31:0]   D_RD1, D_RD2, W_WD;
    logic          trace_valid, trace_ready, trace_full;
    logic [31:0]   trace_pc, trace_wd;
    logic [4:0]    trace_a3;
    logic [DW-1:0] drop_cnt;

    wb_commit #(.TRACE_DEPTH(DEPTH), .DROP_W(DW)) dut (
        .clk(clk), .reset(reset), .W_AO(W_AO), .W_DR(W_DR), .W_pc(W_pc), .W_pc8(W_pc8),
        .W_A3(W_A3), .SelWout_W(SelWout_W), .RegWrite_W(RegWrite_W), .D_A1(D_A1), .D_A2(D_A2),
        .D_RD1(D_RD1), .D_RD2(D_RD2), .W_WD(W_WD), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_pc(trace_pc), .trace_a3(trace_a3), .trace_wd(trace_wd),
        .trace_full(trace_full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  a3;
        logic [31:0] wd;
    } ent_t;

    logic [31:0] m_grf [32];
    ent_t        m_q [$];
    int          m_drop;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_wd();
        case (SelWout_W)
            2'd0:    return W_AO;
            2'd1:    return W_DR;
            2'd2:    return W_pc8;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit cm, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (cm && a == W_A3) return wd;
        return m_grf[a];
    endfunction

    // Check everything visible this cycle, advance the model, then take the edge.
    task automatic step();
        bit          cm;
        logic [31:0] wd;
        #1;
        cm = RegWrite_W && (W_A3 != 0);
        wd = m_wd();
        chk("W_WD", W_WD, wd);
        chk("D_RD1", D_RD1, m_read(D_A1, cm, wd));
        chk("D_RD2", D_RD2, m_read(D_A2, cm, wd));
        chk("trace_valid", {31'd0, trace_valid}, {31'd0, m_q.size() != 0});
        chk("trace_full", {31'd0, trace_full}, {31'd0, m_q.size() == DEPTH});
        chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
        if (m_q.size() != 0) begin
            chk("trace_pc", trace_pc, m_q[0].pc);
            chk("trace_a3", {27'd0, trace_a3}, {27'd0, m_q[0].a3});
            chk("trace_wd", trace_wd, m_q[0].wd);
        end
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
            m_q.delete();
            m_drop = 0;
        end else begin
            if (trace_ready && m_q.size() != 0) void'(m_q.pop_front());
            if (cm) begin
                m_grf[W_A3] = wd;
                if (m_q.size() < DEPTH) m_q.push_back('{pc: W_pc, a3: W_A3, wd: wd});
                else if (m_drop < (1 << DW) - 1) m_drop++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a3, input logic [1:0] sel, input logic [31:0] pc);
        RegWrite_W = 1'b1;
        W_A3 = a3;
        SelWout_W = sel;
        W_pc = pc;
        W_pc8 = pc + 32'd8;
        W_AO = $urandom;
        W_DR = $urandom;
    endtask

    initial begin
        reset = 1'b0; W_AO = 0; W_DR = 0; W_pc = 0; W_pc8 = 0; W_A3 = 0;
        SelWout_W = 0; RegWrite_W = 0; D_A1 = 0; D_A2 = 0; trace_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
        m_drop = 0;
        reset = 1'b1;

        // Reset then read
        D_A1 = 5; D_A2 = 31;
        #1;
        chk("rst_rd1", D_RD1, 32'd0);
        chk("rst_rd2", D_RD2, 32'd0);
        chk("rst_valid", {31'd0, trace_valid}, 32'd0);
        step();

        // Select pc8 and bypass
        wr(8, 2, 32'h3000); D_A1 = 8; trace_ready = 1;
        #1;
        chk("bypass_rd1", D_RD1, 32'h3008);
        step();
        RegWrite_W = 0;
        #1;
        chk("grf_rd1", D_RD1, 32'h3008);
        step();
        wr(8, 3, 32'h3100);
        #1;
        chk("sel3_rd1", D_RD1, 32'd0);
        step();
        RegWrite_W = 0;
        step();

        // $0 guard
        RegWrite_W = 1; W_A3 = 0; W_AO = 32'hFFFF; SelWout_W = 0; D_A1 = 0;
        step();
        RegWrite_W = 0;
        #1;
        chk("zero_novalid", {31'd0, trace_valid}, 32'd0);
        step();

        // FIFO order with held head
        trace_ready = 0;
        wr(3, 0, 32'h3000); step();
        wr(4, 1, 32'h3004); step();
        wr(5, 2, 32'h3008); step();
        RegWrite_W = 0;
        step(); step();
        chk("held_pc", trace_pc, 32'h3000);
        trace_ready = 1;
        repeat (4) step();

        // Overflow: 10 commits into 8 slots, then commit+pop while full
        trace_ready = 0;
        for (int i = 1; i <= 10; i++) begin
            wr(i[4:0], 2'($urandom_range(0, 2)), 32'h4000 + 4 * i);
            D_A1 = i[4:0]; D_A2 = 5'(i - 1);
            step();
        end
        #1;
        chk("ovf_drop", {24'd0, drop_cnt}, 32'd2);
        chk("ovf_full", {31'd0, trace_full}, 32'd1);
        wr(11, 0, 32'h4100); trace_ready = 1;
        step();
        RegWrite_W = 0; trace_ready = 0;
        #1;
        chk("fullpop_drop", {24'd0, drop_cnt}, 32'd2);
        chk("fullpop_full", {31'd0, trace_full}, 32'd1);
        for (int i = 1; i <= 11; i++) begin
            D_A1 = i[4:0];
            step();
        end

        // Reset mid-queue with a commit to $9
        trace_ready = 1;
        repeat (3) step();
        trace_ready = 0;
        wr(9, 0, 32'h5000); reset = 0;
        step();
        reset = 1; RegWrite_W = 0; D_A1 = 9;
        #1;
        chk("rstq_valid", {31'd0, trace_valid}, 32'd0);
        chk("rstq_drop", {24'd0, drop_cnt}, 32'd0);
        chk("rstq_rd9", D_RD1, 32'd0);
        step();

        // Random traffic: alternate drain-heavy and fill-heavy phases
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 199) != 0);
            RegWrite_W  = ($urandom_range(0, 3) != 0);
            W_A3        = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            SelWout_W   = 2'($urandom);
            W_AO        = $urandom;
            W_DR        = $urandom;
            W_pc        = $urandom;
            W_pc8       = $urandom;
            D_A1        = 5'($urandom_range(0, 7));
            D_A2        = ($urandom_range(0, 1) != 0) ? W_A3 : 5'($urandom);
            trace_ready = ((i / 60) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback commit unit at the far end of the W pipeline register. It consumes the W-stage bundle and selects the write-back data. It commits that data into a 32×32 general register file (GRF) with two D-stage read ports that bypass same-cycle writes. Every architectural write is also pushed into a small commit-trace FIFO, drained by a valid/ready consumer (trace printer / co-sim checker).

## Interface
- TRACE_DEPTH, 8, commit-trace FIFO entries; must be a power of two, at least 2
- DROP_W, 8, width of the saturating dropped-trace counter
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
- W_AO  input  32  ALU/address result from the W register
- W_DR  input  32  data-memory read data from the W register
- W_pc  input  32  PC of the W-stage instruction
- W_pc8  input  32  PC+8 link value
- W_A3  input  5  destination register
- SelWout_W  input  2  write-data select: 0=W_AO, 1=W_DR, 2=W_pc8, 3=reserved (selects 32'b0)
- RegWrite_W  input  1  write enable
- D_A1, D_A2  input  5 each  D-stage read addresses
- D_RD1, D_RD2  output  32 each  read data, combinational
- W_WD  output  32  selected write data, combinational; drives the forwarding network
- trace_valid  output  1  FIFO head valid
- trace_ready  input  1  consumer accepts the head
- trace_pc  output  32  PC of the head entry
- trace_a3  output  5  register number of the head entry
- trace_wd  output  32  write data of the head entry
- trace_full  output  1  FIFO holds TRACE_DEPTH entries
- drop_cnt  output  DROP_W  number of commits whose trace was lost

## Operation
- Commit condition: commit = RegWrite_W && (W_A3 != 0). $0 is never written and never traced.
- On commit, GRF[W_A3] <= W_WD at the rising edge.
- Read ports: D_RDn = 0 if D_An==0. Otherwise, if commit && D_An==W_A3, D_RDn = W_WD (internal bypass). Otherwise D_RDn = GRF[D_An].
- Trace push: on commit, {W_pc, W_A3, W_WD} is pushed.
- Trace pop: a pop occurs when trace_valid && trace_ready.
- FIFO: circular buffer with log2(TRACE_DEPTH)+1-bit read and write pointers. Pointers wrap modulo 2·TRACE_DEPTH. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- Push while full without a pop in the same cycle: the GRF write still happens, the entry is discarded, and drop_cnt increments, saturating at all-ones.
- Push while full with a pop in the same cycle: the pop frees a slot, the push succeeds, and there is no drop.
- Pop while empty: ignored; pointers unchanged.
- Head outputs: trace_pc/trace_a3/trace_wd are undefined (don't-care) when trace_valid=0. They are held stable while trace_valid && !trace_ready.

## Timing
- Reset (reset==0 at an edge): all 32 GRF entries are set to 0, both FIFO pointers to 0, drop_cnt=0. After reset, trace_valid=0, trace_full=0, and D_RD1/D_RD2 read 0 for any address. W_WD is purely combinational from its inputs.
- Reset asserted mid-operation discards all queued trace entries and any commit presented in that same cycle; the GRF does not take the write.
- GRF write latency: 1 edge. The bypass makes the value visible on D_RDn in the commit cycle itself.
- Trace latency: an entry pushed at edge N gives trace_valid=1 after edge N if the FIFO was empty.
- Sustained throughput: 1 push + 1 pop per cycle.
- trace_full reflects the post-edge occupancy. It is an advisory output only; the block never stalls the pipeline.

## Test plan
- Reset then read: hold reset=0 for 2 cycles, release, set D_A1=5, D_A2=31 -> D_RD1=0, D_RD2=0, trace_valid=0, drop_cnt=0.
- Select and bypass: RegWrite_W=1, W_A3=8, SelWout_W=2, W_pc8=0x3008, D_A1=8 -> D_RD1=0x3008 in the same cycle. After the edge, with RegWrite_W=0, D_RD1 still =0x3008. Repeat with SelWout_W=3 -> the value written is 0.
- $0 guard: RegWrite_W=1, W_A3=0, W_AO=0xFFFF -> D_RD1 (D_A1=0)=0, no trace push, FIFO occupancy unchanged.
- FIFO order: trace_ready=0, commit 3 writes at PCs 0x3000/0x3004/0x3008 -> trace_valid=1 with head pc=0x3000 held stable. Raise trace_ready -> heads 0x3000, 0x3004, 0x3008 on successive cycles, then trace_valid=0.
- Overflow: trace_ready=0, 10 consecutive commits with TRACE_DEPTH=8 -> trace_full=1, drop_cnt=2, all 10 GRF writes visible. Then one cycle with commit and trace_ready=1 together -> drop_cnt stays 2, occupancy stays 8.
- Reset mid-queue: with 5 entries queued, pulse reset=0 for 1 cycle together with a commit to $9 -> trace_valid=0, drop_cnt=0, GRF[9]=0.
